mux_scan_sequencer: RTL
=======================

Name: mux_scan_sequencer

Overview:
Self-test sequencer placed directly upstream of the 4:1 single-bit multiplexer. It drives the mux data inputs and address lines, and reads back the mux output.
- Accepts a 4-bit test word over a valid/ready handshake.
- Holds the word on in0..in3 and walks the address 00→01→10→11, dwelling a programmable number of cycles per address.
- Samples the mux output at the end of each dwell and serialises each sample out.
- Reports the reassembled word plus a mismatch flag against the word that was loaded.

Parameters:
DWELL, 2, clock cycles each address is held before mux_out is sampled; legal range 1..255.

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-high reset
load_valid  input  1  test word offered
load_ready  output  1  sequencer can accept a word
load_data  input  4  test word; bit i drives in{i}
abort  input  1  synchronous scan cancel
address0  output  1  mux select LSB
address1  output  1  mux select MSB
in0  output  1  mux data input 0
in1  output  1  mux data input 1
in2  output  1  mux data input 2
in3  output  1  mux data input 3
mux_out  input  1  mux output under test
bit_valid  output  1  one-cycle pulse: bit_out holds a new sample
bit_out  output  1  most recent sample
done  output  1  one-cycle pulse: scan complete
captured  output  4  reassembled samples; bit i sampled at address i
mismatch  output  1  captured != loaded word, valid from done onward

Behaviour:
- Clock, reset and registers:
  - One clock; reset is asynchronous and active-high.
  - All outputs are registered.
  - While reset is high, every output is 0, except load_ready = 1. The internal hold word, address index and dwell counter are also 0.
  - Reset asserted mid-scan takes effect immediately. No done is produced and the FSM returns to IDLE.
- FSM, two states: IDLE, SCAN.
- IDLE:
  - load_ready = 1 and address = 00.
  - Accept occurs when load_valid && load_ready at a rising edge. On accept:
    - hold ← load_data;
    - idx ← 0 and dwell count ← 0;
    - captured ← 0 and mismatch ← 0;
    - state → SCAN.
  - In IDLE, abort has no effect.
- SCAN:
  - load_ready = 0; load_valid is ignored.
  - {address1, address0} = idx.
  - Dwell count increments on every edge.
  - On the edge where count == DWELL-1:
    - captured[idx] ← mux_out;
    - bit_out ← mux_out;
    - bit_valid ← 1 for the following cycle only;
    - count ← 0.
  - If idx < 3, idx increments.
  - If idx == 3:
    - state → IDLE;
    - done ← 1 for one cycle;
    - mismatch ← ({mux_out, captured[2:0]} != hold).
- Timing, with accept at edge 0:
  - Samples occur at edges DWELL, 2·DWELL, 3·DWELL and 4·DWELL.
  - The address changes at edges DWELL, 2·DWELL and 3·DWELL.
  - done and load_ready = 1 appear in the same cycle, after edge 4·DWELL.
- in0..in3 always reflect hold. hold is retained after a scan until the next accept.
- captured, mismatch and bit_out hold their values until the next accept or reset.
- Back-to-back operation: a load presented during the done cycle is accepted at the next edge. That edge clears captured and mismatch.
- abort during SCAN:
  - At the next edge: state → IDLE, address → 00, count and idx → 0.
  - No bit_valid or done is produced by that edge, even if it coincides with a sample edge. Abort wins.
  - captured keeps any partial samples; mismatch stays 0.
- DWELL = 1: a sample is taken every edge, and the address advances every cycle.

Test Plan:
1. DWELL=2, ideal mux model, load 4'b1010 accepted at edge 0:
   - bit_valid pulses after edges 2, 4, 6, 8 with bit_out = 0, 1, 0, 1;
   - address steps 00→01→10→11 at edges 2, 4, 6;
   - done after edge 8 with captured = 1010, mismatch = 0, load_ready = 1.
2. mux_out tied to 0, load 4'b1111: captured = 0000 and mismatch = 1 in the done cycle; in0..in3 stay 1 afterwards.
3. Back-to-back: load 4'b0001, then present 4'b1000 with load_valid held high through the done cycle:
   - the second word is accepted at the edge after done, and captured/mismatch clear to 0;
   - the second scan yields captured = 1000, mismatch = 0.
4. Reset asserted between the 2nd and 3rd sample:
   - outputs go to reset values immediately (load_ready = 1, in0..in3 = 0);
   - no done pulse; after release, a fresh load of 4'b0110 completes normally.
5. abort held high at the 3rd sample edge: no bit_valid for that sample, no done, state IDLE, captured = bits 0..1 only, mismatch = 0.
6. DWELL=1, load 4'b0101 and pulse load_valid during SCAN:
   - the mid-scan load is ignored;
   - samples occur at edges 1..4, and done follows edge 4 with captured = 0101.

Source files
------------

// File: rtl/mux_scan_sequencer.sv
// Self-test sequencer for a 4:1 single-bit mux: holds a test word on the data inputs,
// walks the select lines with a programmable dwell and reassembles the sampled output.
module mux_scan_sequencer #(
    parameter int DWELL = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load_valid,
    output logic       load_ready,
    input  logic [3:0] load_data,
    input  logic       abort,
    output logic       address0,
    output logic       address1,
    output logic       in0,
    output logic       in1,
    output logic       in2,
    output logic       in3,
    input  logic       mux_out,
    output logic       bit_valid,
    output logic       bit_out,
    output logic       done,
    output logic [3:0] captured,
    output logic       mismatch
);

    localparam logic [7:0] LAST = 8'(DWELL - 1);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t     state, state_nxt;
    logic [3:0] hold, hold_nxt;
    logic [1:0] idx, idx_nxt;
    logic [7:0] count, count_nxt;
    logic [3:0] captured_nxt;
    logic       mismatch_nxt;
    logic       bit_out_nxt;
    logic       bit_valid_nxt;
    logic       done_nxt;
    logic       load_ready_nxt;

    // Every output comes straight from a flop; reset leaves the sequencer ready for a word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            hold       <= 4'd0;
            idx        <= 2'd0;
            count      <= 8'd0;
            captured   <= 4'd0;
            mismatch   <= 1'b0;
            bit_out    <= 1'b0;
            bit_valid  <= 1'b0;
            done       <= 1'b0;
            load_ready <= 1'b1;
        end else begin
            state      <= state_nxt;
            hold       <= hold_nxt;
            idx        <= idx_nxt;
            count      <= count_nxt;
            captured   <= captured_nxt;
            mismatch   <= mismatch_nxt;
            bit_out    <= bit_out_nxt;
            bit_valid  <= bit_valid_nxt;
            done       <= done_nxt;
            load_ready <= load_ready_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        hold_nxt      = hold;
        idx_nxt       = idx;
        count_nxt     = count;
        captured_nxt  = captured;
        mismatch_nxt  = mismatch;
        bit_out_nxt   = bit_out;
        bit_valid_nxt = 1'b0;
        done_nxt      = 1'b0;

        case (state)
            IDLE: begin
                if (load_valid) begin
                    hold_nxt     = load_data;
                    idx_nxt      = 2'd0;
                    count_nxt    = 8'd0;
                    captured_nxt = 4'd0;
                    mismatch_nxt = 1'b0;
                    state_nxt    = SCAN;
                end
            end
            SCAN: begin
                // Abort beats a coincident sample: nothing is reported for that edge.
                if (abort) begin
                    state_nxt = IDLE;
                    idx_nxt   = 2'd0;
                    count_nxt = 8'd0;
                end else if (count == LAST) begin
                    captured_nxt[idx] = mux_out;
                    bit_out_nxt       = mux_out;
                    bit_valid_nxt     = 1'b1;
                    count_nxt         = 8'd0;
                    if (idx == 2'd3) begin
                        state_nxt    = IDLE;
                        idx_nxt      = 2'd0;
                        done_nxt     = 1'b1;
                        mismatch_nxt = ({mux_out, captured[2:0]} != hold);
                    end else begin
                        idx_nxt = idx + 2'd1;
                    end
                end else begin
                    count_nxt = count + 8'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        load_ready_nxt = (state_nxt == IDLE);
    end

    assign {address1, address0} = idx;
    assign {in3, in2, in1, in0} = hold;

endmodule
